// File: rtl/datamem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// datamem_arbiter_pkg
// Shared definitions for the data-memory arbiter slice. The core decode and
// the data memory use the same MemStatus encodings.
//   MEM_IDLE / MEM_LOAD / MEM_STORE : MemStatus codes (2'b11 is never driven)
//   arb_state_e                     : arbiter grant state
//   mem_op()                        : MemStatus code for a request's We bit
// -----------------------------------------------------------------------------
package datamem_arbiter_pkg;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  function automatic logic [1:0] mem_op(input logic we);
    return we ? MEM_STORE : MEM_LOAD;
  endfunction

endpackage

// File: rtl/datamem_arbiter_if.sv
// -----------------------------------------------------------------------------
// datamem_arbiter_if
// Bundle of every signal between the two requesters, the arbiter and the
// single-port data memory.
//   Requester side : Req/We/Addr/WData in, Ack/RValid/RData out (ports 0 and 1)
//   Memory side    : MemAddr/MemStatus/MemWData out, MemRData in
// Modports: slave = arbiter view, master = requesters + memory view.
//
// Handshake: a requester raises Reqi with Wei/Addri/WDatai and holds all four
// stable until it sees Acki = 1. Acki is combinational and means the access
// is performed in this cycle; the transfer completes at the posedge ending
// that cycle. A requester may drop Reqi before an ack; nothing is issued.
// For a load, RValidi pulses for exactly the cycle after the ack, with RDatai
// carrying the loaded byte (RDatai then holds until the next load).
// -----------------------------------------------------------------------------
interface datamem_arbiter_if #(
  parameter int W = 8
);
  logic         Req0, Req1;
  logic         We0, We1;
  logic [W-1:0] Addr0, Addr1;
  logic [7:0]   WData0, WData1;
  logic         Ack0, Ack1;
  logic         RValid0, RValid1;
  logic [7:0]   RData0, RData1;
  logic [W-1:0] MemAddr;
  logic [1:0]   MemStatus;
  logic [7:0]   MemWData;
  logic [7:0]   MemRData;

  modport slave (
    input  Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, MemRData,
    output Ack0, Ack1, RValid0, RValid1, RData0, RData1,
           MemAddr, MemStatus, MemWData
  );

  modport master (
    output Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1, MemRData,
    input  Ack0, Ack1, RValid0, RValid1, RData0, RData1,
           MemAddr, MemStatus, MemWData
  );
endinterface

// File: rtl/datamem_rr_pick.sv
// -----------------------------------------------------------------------------
// datamem_rr_pick
// Combinational 2-way round-robin picker.
//   req0_i, req1_i : pending requests
//   last_i         : index of the port served most recently
//   any_o          : at least one request pending
//   win_o          : winning port index (valid when any_o = 1)
// -----------------------------------------------------------------------------
module datamem_rr_pick (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic any_o,
  output logic win_o
);

  always_comb begin
    any_o = req0_i | req1_i;
    // On a tie the port that was not served last wins.
    if (req0_i && req1_i) win_o = ~last_i;
    else                  win_o = req1_i;
  end

endmodule

// File: rtl/datamem_arbiter.sv
// -----------------------------------------------------------------------------
// datamem_arbiter
// Shares the single-port 8-bit data memory between the core load/store path
// (port 0) and the loader/debug engine (port 1). Registered round-robin grant
// with a bounded burst per grant and registered load-data return.
//   CLK         : clock, rising edge
//   Reset       : asynchronous, active-high reset
//   bus         : datamem_arbiter_if.slave (requester and memory signals)
//   dbg_state_o : current grant state, for observation only
// Parameters: W (memory address width), MAX_BURST (accesses per grant while
// the other port waits, >= 1).
// -----------------------------------------------------------------------------
module datamem_arbiter
  import datamem_arbiter_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                CLK,
  input  logic                Reset,
  datamem_arbiter_if.slave    bus,
  output arb_state_e          dbg_state_o
);

  localparam int            CW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  logic          rvalid0_q, rvalid1_q;
  logic [7:0]    rdata0_q, rdata1_q;

  logic          any_req, win;
  logic          own_id, own_req, oth_req;
  arb_state_e    oth_st;
  logic          ack0, ack1;

  datamem_rr_pick u_pick (
    .req0_i (bus.Req0),
    .req1_i (bus.Req1),
    .last_i (last_q),
    .any_o  (any_req),
    .win_o  (win)
  );

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    own_id  = (state_q == ST_GNT1);
    own_req = own_id ? bus.Req1 : bus.Req0;
    oth_req = own_id ? bus.Req0 : bus.Req1;
    oth_st  = own_id ? ST_GNT0 : ST_GNT1;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = win ? ST_GNT1 : ST_GNT0;
          cnt_d   = '0;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (own_req) begin
          if (oth_req && (cnt_q == CNT_LAST)) begin
            // Burst exhausted with the other port waiting: hand over with no bubble.
            state_d = oth_st;
            cnt_d   = '0;
            last_d  = own_id;
          end else if (cnt_q != CNT_LAST) begin
            // Counts acked accesses; saturates while uncontended.
            cnt_d = CW'(cnt_q + 1'b1);
          end
        end else begin
          state_d = oth_req ? oth_st : ST_IDLE;
          cnt_d   = '0;
          last_d  = own_id;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic. Reset gates the memory strobe directly so that no store can
  // be issued while Reset is high, independent of the state register.
  always_comb begin
    ack0          = !Reset && (state_q == ST_GNT0) && bus.Req0;
    ack1          = !Reset && (state_q == ST_GNT1) && bus.Req1;
    bus.MemStatus = MEM_IDLE;
    bus.MemAddr   = '0;
    bus.MemWData  = '0;
    if (ack0) begin
      bus.MemStatus = mem_op(bus.We0);
      bus.MemAddr   = bus.Addr0;
      bus.MemWData  = bus.WData0;
    end else if (ack1) begin
      bus.MemStatus = mem_op(bus.We1);
      bus.MemAddr   = bus.Addr1;
      bus.MemWData  = bus.WData1;
    end
    bus.Ack0    = ack0;
    bus.Ack1    = ack1;
    bus.RValid0 = rvalid0_q;
    bus.RValid1 = rvalid1_q;
    bus.RData0  = rdata0_q;
    bus.RData1  = rdata1_q;
    dbg_state_o = state_q;
  end

  // Load return: capture MemRData at the posedge ending a load ack cycle.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= ack0 && !bus.We0;
      rvalid1_q <= ack1 && !bus.We1;
      if (ack0 && !bus.We0) rdata0_q <= bus.MemRData;
      if (ack1 && !bus.We1) rdata1_q <= bus.MemRData;
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
module tb_datamem_arbiter;
  import datamem_arbiter_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  datamem_arbiter_if #(.W(W)) bus();
  arb_state_e dbg_state;

  datamem_arbiter #(.W(W), .MAX_BURST(4)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];
  logic       mem_clear = 1'b1;

  always @(posedge CLK) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (bus.MemStatus == MEM_STORE) begin
      mem[bus.MemAddr] <= bus.MemWData;
    end
  end

  assign bus.MemRData = (bus.MemStatus == MEM_LOAD) ? mem[bus.MemAddr] : 8'h00;

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester contract: fields stable while Req is held without an ack.
  logic        pend0_c = 1'b0, pend1_c = 1'b0;
  logic [16:0] held0, held1;
  always @(posedge CLK) begin
    if (Reset) begin
      pend0_c = 1'b0;
      pend1_c = 1'b0;
    end else begin
      if (pend0_c && bus.Req0)
        assert ({bus.We0, bus.Addr0, bus.WData0} == held0) else $error("contract0 broken");
      if (pend1_c && bus.Req1)
        assert ({bus.We1, bus.Addr1, bus.WData1} == held1) else $error("contract1 broken");
      pend0_c = bus.Req0 && !bus.Ack0;
      pend1_c = bus.Req1 && !bus.Ack1;
      held0   = {bus.We0, bus.Addr0, bus.WData0};
      held1   = {bus.We1, bus.Addr1, bus.WData1};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.Req0 = 0; bus.We0 = 0; bus.Addr0 = '0; bus.WData0 = '0;
    bus.Req1 = 0; bus.We1 = 0; bus.Addr1 = '0; bus.WData1 = '0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] a0, a1, d0, d1;
  logic       pend0, pend1, we0, we1, exp_rv0, exp_rv1;
  logic [7:0] exp_rd0, exp_rd1;

  initial begin
    idle_inputs();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    tick();
    tick();
    mem_clear = 1'b0;

    // Reset values
    check("rst_ack0", bus.Ack0, 0);
    check("rst_ack1", bus.Ack1, 0);
    check("rst_rv0", bus.RValid0, 0);
    check("rst_rv1", bus.RValid1, 0);
    check("rst_rd0", bus.RData0, 0);
    check("rst_rd1", bus.RData1, 0);
    check("rst_status", bus.MemStatus, MEM_IDLE);
    check("rst_addr", bus.MemAddr, 0);
    check("rst_wdata", bus.MemWData, 0);
    check("rst_state", dbg_state, ST_IDLE);
    Reset = 1'b0;
    tick();

    // T1: store 0xA5 to 0x10 on port 0, then load it back
    bus.Req0 = 1; bus.We0 = 1; bus.Addr0 = 8'h10; bus.WData0 = 8'hA5;
    settle();
    check("t1_bubble_ack0", bus.Ack0, 0);
    tick();
    check("t1_st_ack0", bus.Ack0, 1);
    check("t1_st_ack1", bus.Ack1, 0);
    check("t1_st_status", bus.MemStatus, MEM_STORE);
    check("t1_st_addr", bus.MemAddr, 8'h10);
    check("t1_st_wdata", bus.MemWData, 8'hA5);
    ref_mem[8'h10] = 8'hA5;
    tick();
    bus.We0 = 0;
    settle();
    check("t1_mem", mem[8'h10], 8'hA5);
    check("t1_ld_ack0", bus.Ack0, 1);
    check("t1_ld_status", bus.MemStatus, MEM_LOAD);
    tick();
    bus.Req0 = 0;
    settle();
    check("t1_rv0", bus.RValid0, 1);
    check("t1_rd0", bus.RData0, 8'hA5);
    check("t1_rv1", bus.RValid1, 0);
    check("t1_ack0_off", bus.Ack0, 0);
    tick();
    check("t1_rv0_off", bus.RValid0, 0);
    check("t1_rd0_hold", bus.RData0, 8'hA5);

    // T2: simultaneous loads from 0x00 after reset; port 0 wins first
    do_reset();
    bus.Req0 = 1; bus.We0 = 0; bus.Addr0 = 8'h00;
    bus.Req1 = 1; bus.We1 = 0; bus.Addr1 = 8'h00;
    settle();
    check("t2_bubble_ack0", bus.Ack0, 0);
    check("t2_bubble_ack1", bus.Ack1, 0);
    tick();
    check("t2_ack0", bus.Ack0, 1);
    check("t2_ack1_wait", bus.Ack1, 0);
    check("t2_status", bus.MemStatus, MEM_LOAD);
    tick();
    bus.Req0 = 0;
    settle();
    check("t2_rv0", bus.RValid0, 1);
    check("t2_rd0", bus.RData0, 8'h5A);
    check("t2_gap_ack0", bus.Ack0, 0);
    check("t2_gap_ack1", bus.Ack1, 0);
    tick();
    check("t2_ack1", bus.Ack1, 1);
    check("t2_ack0_off", bus.Ack0, 0);
    check("t2_rv0_off", bus.RValid0, 0);
    tick();
    bus.Req1 = 0;
    settle();
    check("t2_rv1", bus.RValid1, 1);
    check("t2_rd1", bus.RData1, 8'h5A);
    check("t2_rv0_excl", bus.RValid0, 0);
    tick();
    check("t2_idle", dbg_state, ST_IDLE);

    // T3: burst fairness, both ports storing continuously
    a0 = 8'h20; a1 = 8'h40;
    bus.Req0 = 1; bus.We0 = 1; bus.Addr0 = a0; bus.WData0 = a0 ^ 8'hC3;
    bus.Req1 = 1; bus.We1 = 1; bus.Addr1 = a1; bus.WData1 = a1 ^ 8'h3C;
    settle();
    check("t3_bubble_ack0", bus.Ack0, 0);
    check("t3_bubble_ack1", bus.Ack1, 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      bus.Addr0 = a0; bus.WData0 = a0 ^ 8'hC3;
      bus.Addr1 = a1; bus.WData1 = a1 ^ 8'h3C;
      settle();
      check("t3_ack0", bus.Ack0, ((k / 4) % 2) == 0);
      check("t3_ack1", bus.Ack1, ((k / 4) % 2) == 1);
      check("t3_status", bus.MemStatus, MEM_STORE);
      if (bus.Ack0) begin
        ref_mem[a0] = a0 ^ 8'hC3;
        a0 = a0 + 8'd1;
      end
      if (bus.Ack1) begin
        ref_mem[a1] = a1 ^ 8'h3C;
        a1 = a1 + 8'd1;
      end
    end
    tick();
    bus.Req0 = 0; bus.Req1 = 0;
    settle();
    check("t3_end_ack0", bus.Ack0, 0);
    check("t3_end_ack1", bus.Ack1, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t3_mem0", mem[8'h20 + i], 8'(8'h20 + i) ^ 8'hC3);
      check("t3_mem1", mem[8'h40 + i], 8'(8'h40 + i) ^ 8'h3C);
    end

    // T4: port 1 streams 10 loads uncontended
    bus.Req1 = 1; bus.We1 = 0; bus.Addr1 = 8'h20;
    settle();
    check("t4_bubble_ack1", bus.Ack1, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k > 0) begin
        check("t4_rv1", bus.RValid1, 1);
        check("t4_rd1", bus.RData1, ref_mem[8'h20 + k - 1]);
        bus.Addr1 = 8'(8'h20 + k);
      end
      settle();
      check("t4_ack1", bus.Ack1, 1);
      check("t4_status", bus.MemStatus, MEM_LOAD);
      check("t4_state", dbg_state, ST_GNT1);
      check("t4_rv0", bus.RValid0, 0);
    end
    tick();
    bus.Req1 = 0;
    check("t4_rv1_last", bus.RValid1, 1);
    check("t4_rd1_last", bus.RData1, ref_mem[8'h29]);
    settle();
    check("t4_ack1_off", bus.Ack1, 0);
    tick();
    check("t4_rv1_off", bus.RValid1, 0);
    check("t4_idle", dbg_state, ST_IDLE);

    // T5: reset during a port 1 load ack cycle
    bus.Req0 = 1; bus.We0 = 1; bus.Addr0 = 8'h77; bus.WData0 = 8'h3C;
    tick();
    settle();
    check("t5_st_ack0", bus.Ack0, 1);
    tick();
    bus.Req0 = 0;
    ref_mem[8'h77] = 8'h3C;
    tick();
    bus.Req1 = 1; bus.We1 = 0; bus.Addr1 = 8'h77;
    tick();
    settle();
    check("t5_ack1", bus.Ack1, 1);
    check("t5_status_ld", bus.MemStatus, MEM_LOAD);
    Reset = 1'b1;
    settle();
    check("t5_status_rst", bus.MemStatus, MEM_IDLE);
    check("t5_ack1_rst", bus.Ack1, 0);
    check("t5_state_rst", dbg_state, ST_IDLE);
    tick();
    check("t5_rv1_a", bus.RValid1, 0);
    bus.Req1 = 0;
    tick();
    check("t5_rv1_b", bus.RValid1, 0);
    Reset = 1'b0;
    tick();
    check("t5_rv1_c", bus.RValid1, 0);
    check("t5_mem", mem[8'h77], 8'h3C);

    // T6: random traffic with protocol and data checks
    pend0 = 0; pend1 = 0; exp_rv0 = 0; exp_rv1 = 0; exp_rd0 = '0; exp_rd1 = '0;
    we0 = 0; we1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      check("r_rv0", bus.RValid0, exp_rv0);
      check("r_rv1", bus.RValid1, exp_rv1);
      if (exp_rv0) check("r_rd0", bus.RData0, exp_rd0);
      if (exp_rv1) check("r_rd1", bus.RData1, exp_rd1);
      exp_rv0 = 0; exp_rv1 = 0;
      if (!pend0 && ($urandom_range(0, 2) != 0)) begin
        pend0 = 1; we0 = 1'($urandom_range(0, 1));
        a0 = 8'h80 + 8'($urandom_range(0, 15)); d0 = 8'($urandom_range(0, 255));
      end
      if (!pend1 && ($urandom_range(0, 2) != 0)) begin
        pend1 = 1; we1 = 1'($urandom_range(0, 1));
        a1 = 8'h80 + 8'($urandom_range(0, 15)); d1 = 8'($urandom_range(0, 255));
      end
      bus.Req0 = pend0; bus.We0 = we0; bus.Addr0 = a0; bus.WData0 = d0;
      bus.Req1 = pend1; bus.We1 = we1; bus.Addr1 = a1; bus.WData1 = d1;
      settle();
      check("r_status11", bus.MemStatus == 2'b11, 0);
      check("r_two_acks", bus.Ack0 && bus.Ack1, 0);
      check("r_two_rv", bus.RValid0 && bus.RValid1, 0);
      check("r_ack0_noreq", bus.Ack0 && !bus.Req0, 0);
      check("r_ack1_noreq", bus.Ack1 && !bus.Req1, 0);
      if (bus.Ack0) begin
        if (we0) ref_mem[a0] = d0;
        else begin exp_rv0 = 1; exp_rd0 = ref_mem[a0]; end
        pend0 = 0;
      end
      if (bus.Ack1) begin
        if (we1) ref_mem[a1] = d1;
        else begin exp_rv1 = 1; exp_rd1 = ref_mem[a1]; end
        pend1 = 0;
      end
    end
    tick();
    idle_inputs();
    check("r_rv0_tail", bus.RValid0, exp_rv0);
    check("r_rv1_tail", bus.RValid1, exp_rv1);
    if (exp_rv0) check("r_rd0_tail", bus.RData0, exp_rd0);
    if (exp_rv1) check("r_rd1_tail", bus.RData1, exp_rd1);
    tick();
    tick();
    for (int i = 0; i < 256; i++) check("r_mem", mem[i], ref_mem[i]);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
